// File: rtl/fpu_muldiv_arbiter.sv
// -----------------------------------------------------------------------------
// fpu_muldiv_arbiter
//
// Shares one 16-bit half-precision mul/div unit between NREQ requesters.
// Requests are granted round-robin and only one operation is in flight at a
// time. A granted operation is latched, the unit is started with a one-cycle
// md_start pulse, and its result and flags come back on a valid/ready response
// port tagged with the requester index. If the unit does not answer within
// TIMEOUT wait cycles, the operation is aborted and returned with rsp_err=1.
//
// Ports
//   clk, reset                 clock (rising edge), asynchronous active-high reset
//   req_valid_i / req_ready_o  per-requester request handshake; ready is a
//                              one-hot grant, raised only while idle
//   req_x_i, req_y_i           operands, requester i in bits [16*i+15:16*i]
//   req_op_i                   per-requester op: 0 = multiply, 1 = divide
//   md_start_o                 one-cycle start pulse to the unit
//   md_x_o, md_y_o, md_muldiv_o latched operands and op to the unit
//   md_done_i, md_result_i,    unit completion (sticky until next start),
//   md_ofuf_i                  result and flags (01 underflow, 10 overflow)
//   rsp_valid_o / rsp_ready_i  response handshake
//   rsp_id_o, rsp_result_o,    served requester, captured result and flags,
//   rsp_ofuf_o, rsp_err_o      timeout-abort flag
//
// Build option
//   FPU_ARB_ZERO_BYPASS_EN     when defined, a granted op with X or Y equal to
//                              zero skips the unit and responds directly with
//                              result 0 (ofuf=10 for nonzero/0 divide).
// -----------------------------------------------------------------------------
module fpu_muldiv_arbiter #(
  parameter int NREQ    = 4,
  parameter int IDW     = 2,
  parameter int TIMEOUT = 63
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NREQ-1:0]    req_valid_i,
  output logic [NREQ-1:0]    req_ready_o,
  input  logic [16*NREQ-1:0] req_x_i,
  input  logic [16*NREQ-1:0] req_y_i,
  input  logic [NREQ-1:0]    req_op_i,
  output logic               md_start_o,
  output logic [15:0]        md_x_o,
  output logic [15:0]        md_y_o,
  output logic               md_muldiv_o,
  input  logic               md_done_i,
  input  logic [15:0]        md_result_i,
  input  logic [1:0]         md_ofuf_i,
  output logic               rsp_valid_o,
  input  logic               rsp_ready_i,
  output logic [IDW-1:0]     rsp_id_o,
  output logic [15:0]        rsp_result_o,
  output logic [1:0]         rsp_ofuf_o,
  output logic               rsp_err_o
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_RESP
  } state_e;

  state_e         state_q;
  logic [IDW-1:0] rr_ptr_q;
  logic [IDW-1:0] rr_ptr_d;
  logic [CW-1:0]  wait_cnt_q;
  logic           md_start_q;
  logic [15:0]    md_x_q;
  logic [15:0]    md_y_q;
  logic           md_muldiv_q;
  logic           rsp_valid_q;
  logic [IDW-1:0] rsp_id_q;
  logic [15:0]    rsp_result_q;
  logic [1:0]     rsp_ofuf_q;
  logic           rsp_err_q;

  logic           win_found;
  logic [IDW-1:0] win_idx;
  logic [NREQ-1:0] grant_oh;
  logic           handshake;
  logic [15:0]    win_x;
  logic [15:0]    win_y;
  logic           win_op;
  logic           bypass;

  // Round-robin search: first valid requester starting at rr_ptr_q, wrapping.
  always_comb begin
    int cand;
    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    for (int k = 0; k < NREQ; k++) begin
      cand = int'(rr_ptr_q) + k;
      if (cand >= NREQ) cand = cand - NREQ;
      if (!win_found && req_valid_i[cand]) begin
        win_found = 1'b1;
        win_idx   = IDW'(cand);
      end
    end
  end

  // Grant is only offered while idle; held low during reset as well.
  always_comb begin
    grant_oh = '0;
    if (state_q == S_IDLE && !reset && win_found) grant_oh[win_idx] = 1'b1;
  end

  assign req_ready_o = grant_oh;
  // The winner is valid by construction, so any grant is a handshake.
  assign handshake   = |grant_oh;
  assign win_x       = req_x_i[16*win_idx +: 16];
  assign win_y       = req_y_i[16*win_idx +: 16];
  assign win_op      = req_op_i[win_idx];
  assign rr_ptr_d    = (win_idx == IDW'(NREQ - 1)) ? '0 : win_idx + 1'b1;

`ifdef FPU_ARB_ZERO_BYPASS_EN
  assign bypass = (win_x == 16'h0000) || (win_y == 16'h0000);
`else
  assign bypass = 1'b0;
`endif

  // NOTE: all state and registered outputs update with non-blocking
  // assignments so every flop samples the pre-edge values consistently.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      rr_ptr_q     <= '0;
      wait_cnt_q   <= '0;
      md_start_q   <= 1'b0;
      md_x_q       <= '0;
      md_y_q       <= '0;
      md_muldiv_q  <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= '0;
      rsp_result_q <= '0;
      rsp_ofuf_q   <= '0;
      rsp_err_q    <= 1'b0;
    end else begin
      md_start_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (handshake) begin
            md_x_q      <= win_x;
            md_y_q      <= win_y;
            md_muldiv_q <= win_op;
            rsp_id_q    <= win_idx;
            rr_ptr_q    <= rr_ptr_d;
            if (bypass) begin
              rsp_result_q <= 16'h0000;
              rsp_ofuf_q   <= (win_op && win_y == 16'h0000 && win_x != 16'h0000) ? 2'b10 : 2'b00;
              rsp_err_q    <= 1'b0;
              rsp_valid_q  <= 1'b1;
              state_q      <= S_RESP;
            end else begin
              md_start_q <= 1'b1;
              state_q    <= S_LAUNCH;
            end
          end
        end
        // md_done may still hold the previous op's sticky done here; ignore it.
        S_LAUNCH: begin
          wait_cnt_q <= '0;
          state_q    <= S_WAIT;
        end
        S_WAIT: begin
          wait_cnt_q <= wait_cnt_q + 1'b1;
          if (md_done_i) begin
            rsp_result_q <= md_result_i;
            rsp_ofuf_q   <= md_ofuf_i;
            rsp_err_q    <= 1'b0;
            rsp_valid_q  <= 1'b1;
            state_q      <= S_RESP;
          end else if (wait_cnt_q == CW'(TIMEOUT - 1)) begin
            // This is the TIMEOUT-th wait cycle without done: abort.
            rsp_result_q <= 16'h0000;
            rsp_ofuf_q   <= 2'b00;
            rsp_err_q    <= 1'b1;
            rsp_valid_q  <= 1'b1;
            state_q      <= S_RESP;
          end
        end
        S_RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign md_start_o   = md_start_q;
  assign md_x_o       = md_x_q;
  assign md_y_o       = md_y_q;
  assign md_muldiv_o  = md_muldiv_q;
  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_id_o     = rsp_id_q;
  assign rsp_result_o = rsp_result_q;
  assign rsp_ofuf_o   = rsp_ofuf_q;
  assign rsp_err_o    = rsp_err_q;

endmodule

// File: tb/tb_fpu_muldiv_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fpu_muldiv_arbiter
//
// Directed bench for fpu_muldiv_arbiter (NREQ=4, TIMEOUT=63). A small unit
// model answers md_start with done after a programmable latency (0 = never),
// producing a fixed-function result so the bench knows every expected value.
// -----------------------------------------------------------------------------
module tb_fpu_muldiv_arbiter;

  logic        clk;
  logic        reset;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [63:0] req_x;
  logic [63:0] req_y;
  logic [3:0]  req_op;
  logic        md_start;
  logic [15:0] md_x;
  logic [15:0] md_y;
  logic        md_muldiv;
  logic        md_done;
  logic [15:0] md_result;
  logic [1:0]  md_ofuf;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_id;
  logic [15:0] rsp_result;
  logic [1:0]  rsp_ofuf;
  logic        rsp_err;

  int checks;
  int failures;

  fpu_muldiv_arbiter #(.NREQ(4), .IDW(2), .TIMEOUT(63)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_x_i      (req_x),
    .req_y_i      (req_y),
    .req_op_i     (req_op),
    .md_start_o   (md_start),
    .md_x_o       (md_x),
    .md_y_o       (md_y),
    .md_muldiv_o  (md_muldiv),
    .md_done_i    (md_done),
    .md_result_i  (md_result),
    .md_ofuf_i    (md_ofuf),
    .rsp_valid_o  (rsp_valid),
    .rsp_ready_i  (rsp_ready),
    .rsp_id_o     (rsp_id),
    .rsp_result_o (rsp_result),
    .rsp_ofuf_o   (rsp_ofuf),
    .rsp_err_o    (rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- unit model ----------------
  int         model_lat;   // cycles from start to done; 0 = never
  logic [1:0] model_ofuf;
  int         model_cnt;

  // 2.0 * 3.0 = 6.0 for the reference multiply, otherwise a cheap mix of the
  // operands so every requester's result is distinct.
  function automatic logic [15:0] fake_unit(input logic [15:0] x, input logic [15:0] y,
                                            input logic op);
    if (!op && x == 16'h4000 && y == 16'h4200) return 16'h4600;
    return x ^ y ^ {op, 15'b0};
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      md_done   <= 1'b0;
      model_cnt <= 0;
      md_result <= '0;
    end else if (md_start) begin
      md_done   <= 1'b0;
      model_cnt <= model_lat - 1;
      md_result <= fake_unit(md_x, md_y, md_muldiv);
    end else if (model_cnt > 1) begin
      model_cnt <= model_cnt - 1;
    end else if (model_cnt == 1) begin
      md_done   <= 1'b1;
      model_cnt <= 0;
    end
  end

  assign md_ofuf = model_ofuf;

  // ---------------- helpers (stimulus only) ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  // Presents one request, records the grant seen, and steps past the grant edge.
  task automatic issue(input int id, input logic [15:0] x, input logic [15:0] y,
                       input logic op, output logic [3:0] gnt);
    req_x[16*id +: 16] = x;
    req_y[16*id +: 16] = y;
    req_op[id]         = op;
    req_valid          = 4'b0001 << id;
    #1;
    gnt = req_ready;
    tick();
    req_valid = '0;
  endtask

  // Counts cycles after the grant edge until rsp_valid (1 = first cycle).
  task automatic wait_rsp(input int bound, output int cycles);
    cycles = 1;
    while (!rsp_valid && cycles < bound) begin
      tick();
      cycles++;
    end
  endtask

  task automatic accept();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset     = 1'b1;
    req_valid = 4'hF;
    req_x     = 64'h1111_2222_3333_4444;
    req_y     = 64'h5555_6666_7777_8888;
    #1;
    checks++;
    if (req_ready !== 4'b0000) begin
      failures++;
      $display("FAIL reset_req_ready: got %b expected 0000", req_ready);
    end
    checks++;
    if ({md_start, md_x, md_y, md_muldiv, rsp_valid, rsp_id, rsp_result, rsp_ofuf, rsp_err} !== 56'h0) begin
      failures++;
      $display("FAIL reset_outputs: got %h expected 0",
               {md_start, md_x, md_y, md_muldiv, rsp_valid, rsp_id, rsp_result, rsp_ofuf, rsp_err});
    end
    tick();
    req_valid = '0;
    reset     = 1'b0;
    tick();
  endtask

  task automatic test_single_mul();
    model_lat  = 3;
    model_ofuf = 2'b00;
    rsp_ready  = 1'b0;
    req_x[15:0] = 16'h4000;
    req_y[15:0] = 16'h4200;
    req_op[0]   = 1'b0;
    req_valid   = 4'b0001;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      failures++;
      $display("FAIL single_grant: got %b expected 0001", req_ready);
    end
    tick();                       // grant + 1
    req_valid = '0;
    checks++;
    if ({md_start, md_x, md_y, md_muldiv} !== {1'b1, 16'h4000, 16'h4200, 1'b0}) begin
      failures++;
      $display("FAIL single_launch: start/x/y/op got %b/%h/%h/%b expected 1/4000/4200/0",
               md_start, md_x, md_y, md_muldiv);
    end
    tick();                       // grant + 2
    checks++;
    if (md_start !== 1'b0) begin
      failures++;
      $display("FAIL single_start_pulse: md_start got %b expected 0", md_start);
    end
    tick();                       // grant + 3
    tick();                       // grant + 4
    checks++;
    if (rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL single_early_rsp: rsp_valid got %b expected 0 at grant+4", rsp_valid);
    end
    tick();                       // grant + 5
    checks++;
    if ({rsp_valid, rsp_id, rsp_result, rsp_ofuf, rsp_err} !== {1'b1, 2'd0, 16'h4600, 2'b00, 1'b0}) begin
      failures++;
      $display("FAIL single_rsp: v/id/res/ofuf/err got %b/%0d/%h/%b/%b expected 1/0/4600/00/0",
               rsp_valid, rsp_id, rsp_result, rsp_ofuf, rsp_err);
    end
    accept();
    checks++;
    if (rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL single_rsp_drop: rsp_valid got %b expected 0", rsp_valid);
    end
  endtask

  task automatic test_back_to_back();
    int         exp_order[5];
    int         grants;
    int         rsps;
    int         starts;
    int         eid;
    bit         busy;
    bit         overlap;
    logic [3:0] exp_gnt;
    logic [15:0] exp_res;
    exp_order = '{0, 1, 2, 3, 0};
    grants = 0; rsps = 0; starts = 0; busy = 1'b0; overlap = 1'b0;
    do_reset();
    model_lat  = 3;
    model_ofuf = 2'b00;
    for (int i = 0; i < 4; i++) begin
      req_x[16*i +: 16] = 16'h3C00 + 16'(i);
      req_y[16*i +: 16] = 16'h4000 + 16'(i);
      req_op[i]         = i[0];
    end
    rsp_ready = 1'b1;
    req_valid = 4'hF;
    #1;
    for (int cyc = 0; cyc < 300 && rsps < 5; cyc++) begin
      if (req_ready != 4'b0000) begin
        if (busy) overlap = 1'b1;
        busy = 1'b1;
        if (grants < 5) begin
          exp_gnt = 4'b0001 << exp_order[grants];
          checks++;
          if (req_ready !== exp_gnt) begin
            failures++;
            $display("FAIL b2b_grant%0d: got %b expected %b", grants, req_ready, exp_gnt);
          end
        end
        grants++;
      end
      if (md_start) starts++;
      if (rsp_valid) begin
        eid     = exp_order[rsps];
        exp_res = fake_unit(16'h3C00 + 16'(eid), 16'h4000 + 16'(eid), eid[0]);
        checks++;
        if ({rsp_id, rsp_result, rsp_err} !== {2'(eid), exp_res, 1'b0}) begin
          failures++;
          $display("FAIL b2b_rsp%0d: id/res/err got %0d/%h/%b expected %0d/%h/0",
                   rsps, rsp_id, rsp_result, rsp_err, eid, exp_res);
        end
        rsps++;
        busy = 1'b0;
        if (rsps == 5) req_valid = '0;
      end
      tick();
    end
    rsp_ready = 1'b0;
    checks++;
    if (rsps != 5 || grants != 5) begin
      failures++;
      $display("FAIL b2b_count: grants/rsps got %0d/%0d expected 5/5", grants, rsps);
    end
    checks++;
    if (starts != 5) begin
      failures++;
      $display("FAIL b2b_starts: md_start pulses got %0d expected 5", starts);
    end
    checks++;
    if (overlap) begin
      failures++;
      $display("FAIL b2b_overlap: grant seen with op in flight, got 1 expected 0");
    end
  endtask

  task automatic test_timeout();
    logic [3:0] gnt;
    int         cyc;
    do_reset();
    model_lat  = 0;               // unit never answers
    model_ofuf = 2'b11;
    issue(2, 16'h4400, 16'h4200, 1'b0, gnt);
    checks++;
    if (gnt !== 4'b0100) begin
      failures++;
      $display("FAIL tmo_grant: got %b expected 0100", gnt);
    end
    wait_rsp(100, cyc);
    checks++;
    if (cyc != 65) begin
      failures++;
      $display("FAIL tmo_latency: rsp after %0d cycles expected 65", cyc);
    end
    checks++;
    if ({rsp_valid, rsp_id, rsp_result, rsp_ofuf, rsp_err} !== {1'b1, 2'd2, 16'h0000, 2'b00, 1'b1}) begin
      failures++;
      $display("FAIL tmo_rsp: v/id/res/ofuf/err got %b/%0d/%h/%b/%b expected 1/2/0000/00/1",
               rsp_valid, rsp_id, rsp_result, rsp_ofuf, rsp_err);
    end
    accept();
    // Done arriving in the last allowed wait cycle wins over the timeout.
    model_lat  = 63;
    model_ofuf = 2'b01;
    issue(3, 16'h4800, 16'h3C00, 1'b1, gnt);
    checks++;
    if (gnt !== 4'b1000) begin
      failures++;
      $display("FAIL tmo_next_grant: got %b expected 1000", gnt);
    end
    wait_rsp(100, cyc);
    checks++;
    if (cyc != 65) begin
      failures++;
      $display("FAIL edge_latency: rsp after %0d cycles expected 65", cyc);
    end
    checks++;
    if ({rsp_valid, rsp_id, rsp_result, rsp_ofuf, rsp_err} !== {1'b1, 2'd3, 16'hF400, 2'b01, 1'b0}) begin
      failures++;
      $display("FAIL edge_rsp: v/id/res/ofuf/err got %b/%0d/%h/%b/%b expected 1/3/F400/01/0",
               rsp_valid, rsp_id, rsp_result, rsp_ofuf, rsp_err);
    end
    accept();
  endtask

  task automatic test_backpressure();
    logic [3:0] gnt;
    int         cyc;
    int         extra;
    do_reset();
    model_lat  = 3;
    model_ofuf = 2'b10;
    issue(1, 16'h4400, 16'h3C00, 1'b1, gnt);
    checks++;
    if (gnt !== 4'b0010) begin
      failures++;
      $display("FAIL bp_grant: got %b expected 0010", gnt);
    end
    wait_rsp(20, cyc);
    checks++;
    if (cyc != 5) begin
      failures++;
      $display("FAIL bp_latency: rsp after %0d cycles expected 5", cyc);
    end
    req_valid = 4'hF;
    #1;
    for (int i = 0; i < 10; i++) begin
      checks++;
      if ({rsp_valid, rsp_id, rsp_result, rsp_ofuf, rsp_err} !== {1'b1, 2'd1, 16'hF800, 2'b10, 1'b0}) begin
        failures++;
        $display("FAIL bp_hold%0d: v/id/res/ofuf/err got %b/%0d/%h/%b/%b expected 1/1/F800/10/0",
                 i, rsp_valid, rsp_id, rsp_result, rsp_ofuf, rsp_err);
      end
      checks++;
      if (req_ready !== 4'b0000) begin
        failures++;
        $display("FAIL bp_ready%0d: got %b expected 0000", i, req_ready);
      end
      tick();
    end
    rsp_ready = 1'b1;
    #1;
    checks++;
    if (req_ready !== 4'b0000) begin
      failures++;
      $display("FAIL bp_accept_ready: got %b expected 0000", req_ready);
    end
    tick();
    rsp_ready = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL bp_drop: rsp_valid got %b expected 0", rsp_valid);
    end
    checks++;
    if (req_ready !== 4'b0100) begin
      failures++;
      $display("FAIL bp_next_grant: got %b expected 0100", req_ready);
    end
    req_valid = '0;
    extra = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (rsp_valid) extra++;
    end
    checks++;
    if (extra != 0) begin
      failures++;
      $display("FAIL bp_single_handshake: extra rsp cycles got %0d expected 0", extra);
    end
  endtask

  task automatic test_reset_in_wait();
    logic [3:0] gnt;
    int         cyc;
    int         spurious;
    do_reset();
    model_lat  = 10;
    model_ofuf = 2'b00;
    issue(0, 16'h4400, 16'h4000, 1'b1, gnt);
    checks++;
    if (gnt !== 4'b0001) begin
      failures++;
      $display("FAIL rstw_grant: got %b expected 0001", gnt);
    end
    tick();                       // grant + 2, WAIT
    tick();                       // grant + 3, WAIT
    req_valid = 4'hF;
    reset     = 1'b1;
    #1;
    checks++;
    if (req_ready !== 4'b0000) begin
      failures++;
      $display("FAIL rstw_req_ready: got %b expected 0000", req_ready);
    end
    checks++;
    if ({md_start, md_x, md_y, md_muldiv, rsp_valid, rsp_id, rsp_result, rsp_ofuf, rsp_err} !== 56'h0) begin
      failures++;
      $display("FAIL rstw_outputs: got %h expected 0",
               {md_start, md_x, md_y, md_muldiv, rsp_valid, rsp_id, rsp_result, rsp_ofuf, rsp_err});
    end
    tick();
    req_valid = '0;
    reset     = 1'b0;
    spurious  = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (rsp_valid) spurious++;
    end
    checks++;
    if (spurious != 0) begin
      failures++;
      $display("FAIL rstw_no_rsp: rsp_valid cycles got %0d expected 0", spurious);
    end
    model_lat = 3;
    issue(3, 16'h3C00, 16'h4000, 1'b0, gnt);
    checks++;
    if (gnt !== 4'b1000) begin
      failures++;
      $display("FAIL rstw_next_grant: got %b expected 1000", gnt);
    end
    wait_rsp(20, cyc);
    checks++;
    if (cyc != 5 || {rsp_id, rsp_result, rsp_err} !== {2'd3, 16'h7C00, 1'b0}) begin
      failures++;
      $display("FAIL rstw_next_rsp: lat/id/res/err got %0d/%0d/%h/%b expected 5/3/7C00/0",
               cyc, rsp_id, rsp_result, rsp_err);
    end
    accept();
  endtask

  task automatic test_zero_operand();
    logic [3:0] gnt;
    int         cyc;
    do_reset();
    model_lat  = 3;
    model_ofuf = 2'b00;
    issue(2, 16'h3C00, 16'h0000, 1'b1, gnt);
    checks++;
    if (gnt !== 4'b0100) begin
      failures++;
      $display("FAIL zero_grant: got %b expected 0100", gnt);
    end
`ifdef FPU_ARB_ZERO_BYPASS_EN
    checks++;
    if (md_start !== 1'b0) begin
      failures++;
      $display("FAIL zero_no_start: md_start got %b expected 0", md_start);
    end
    checks++;
    if ({rsp_valid, rsp_id, rsp_result, rsp_ofuf, rsp_err} !== {1'b1, 2'd2, 16'h0000, 2'b10, 1'b0}) begin
      failures++;
      $display("FAIL zero_div_rsp: v/id/res/ofuf/err got %b/%0d/%h/%b/%b expected 1/2/0000/10/0",
               rsp_valid, rsp_id, rsp_result, rsp_ofuf, rsp_err);
    end
    accept();
    issue(3, 16'h0000, 16'h4000, 1'b0, gnt);
    checks++;
    if (md_start !== 1'b0 || {rsp_valid, rsp_id, rsp_result, rsp_ofuf, rsp_err} !== {1'b1, 2'd3, 16'h0000, 2'b00, 1'b0}) begin
      failures++;
      $display("FAIL zero_mul_rsp: start/v/id/res/ofuf got %b/%b/%0d/%h/%b expected 0/1/3/0000/00",
               md_start, rsp_valid, rsp_id, rsp_result, rsp_ofuf);
    end
    accept();
    issue(0, 16'h0000, 16'h0000, 1'b1, gnt);
    checks++;
    if ({rsp_valid, rsp_id, rsp_result, rsp_ofuf, rsp_err} !== {1'b1, 2'd0, 16'h0000, 2'b00, 1'b0}) begin
      failures++;
      $display("FAIL zero_0div0_rsp: v/id/res/ofuf/err got %b/%0d/%h/%b/%b expected 1/0/0000/00/0",
               rsp_valid, rsp_id, rsp_result, rsp_ofuf, rsp_err);
    end
    accept();
`else
    checks++;
    if ({md_start, rsp_valid} !== 2'b10) begin
      failures++;
      $display("FAIL zero_launch: start/rsp_valid got %b/%b expected 1/0", md_start, rsp_valid);
    end
    wait_rsp(20, cyc);
    checks++;
    if (cyc != 5 || {rsp_id, rsp_result, rsp_ofuf, rsp_err} !== {2'd2, 16'hBC00, 2'b00, 1'b0}) begin
      failures++;
      $display("FAIL zero_unit_rsp: lat/id/res/ofuf/err got %0d/%0d/%h/%b/%b expected 5/2/BC00/00/0",
               cyc, rsp_id, rsp_result, rsp_ofuf, rsp_err);
    end
    accept();
`endif
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    reset      = 1'b1;
    req_valid  = '0;
    req_x      = '0;
    req_y      = '0;
    req_op     = '0;
    rsp_ready  = 1'b0;
    model_lat  = 3;
    model_ofuf = 2'b00;
    test_reset();
    test_single_mul();
    test_back_to_back();
    test_timeout();
    test_backpressure();
    test_reset_in_wait();
    test_zero_operand();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no summary expected one");
    $fatal(1, "watchdog");
  end

endmodule
